fetch_buffered: RTL

Parametrised RV32 instruction fetch unit with a prefetch queue between the I-cache and decode. It generates sequential fetch addresses, keeps up to `MAX_OUTSTANDING` I-cache requests in flight, and buffers returned instructions with their PCs in a `FIFO_DEPTH`-entry queue. Decode pulls from the queue with a valid/ready handshake. A redirect flushes the queue, discards stale in-flight responses and restarts fetch at the new PC.

---
 rtl/fetch_buffered.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_buffered.sv
// rtl/fetch_buffered.sv - RV32 sequential fetch unit with prefetch queue
// Credit-based issue keeps every live I-cache response guaranteed a queue slot.
module fetch_buffered #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redir_i,
  input  logic [31:0] redir_pc_i,
  output logic        ic_req_valid_o,
  input  logic        ic_req_ready_i,
  output logic [31:0] ic_req_addr_o,
  input  logic        ic_rsp_valid_i,
  input  logic [31:0] ic_rsp_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] pc_q_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = 4;
  localparam logic [31:0] DEPTH_U = FIFO_DEPTH;
  localparam logic [31:0] MAXO_U  = MAX_OUTSTANDING;

  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [OW-1:0] inflight_q, inflight_d, drop_cnt_q, drop_cnt_d, live;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   occ, redir_target;
  logic          req_fire, rsp_drop, enq, deq;

  assign live = inflight_q - drop_cnt_q;
  assign occ  = 32'(count_q) + 32'(live);

  assign ic_req_valid_o = !rst && !redir_i && (32'(inflight_q) < MAXO_U) && (occ < DEPTH_U);
  assign ic_req_addr_o  = fetch_pc_q;
  assign pc_q_o         = rst ? RESET_PC : fetch_pc_q;

  assign instr_valid_o = !rst && !redir_i && (count_q != '0);
  assign {instr_o, instr_pc_o} = (rst || count_q == '0) ? 64'h0 : mem_q[rd_ptr_q];

  assign req_fire     = ic_req_valid_o && ic_req_ready_i;
  assign rsp_drop     = ic_rsp_valid_i && (drop_cnt_q != '0);
  assign enq          = ic_rsp_valid_i && !rsp_drop && !redir_i;
  assign deq          = instr_valid_o && instr_ready_i;
  assign redir_target = {redir_pc_i[31:2], 2'b00};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + OW'(req_fire) - OW'(ic_rsp_valid_i);
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redir_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = redir_target;
      rsp_pc_d   = redir_target;
      drop_cnt_d = inflight_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_drop) drop_cnt_d = drop_cnt_q - OW'(1);
      if (enq) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) mem_q[wr_ptr_q] <= {ic_rsp_data_i, rsp_pc_q};
  end

  // A response with nothing in flight means the I-cache and this unit disagree.
  always_ff @(posedge clk) begin
    if (!rst && ic_rsp_valid_i) assert (inflight_q != '0);
  end
endmodule
